// File: rtl/instr_buffer_pkg.sv
// instr_buffer_pkg: fetch-to-buffer packet type and the shared default buffer depth.
`ifndef IB_DEPTH_DEF
`define IB_DEPTH_DEF 8
`endif
package instr_buffer_pkg;
    localparam int IB_DEPTH_DEFAULT = `IB_DEPTH_DEF;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } IF_IB_PACKET;
endpackage

// File: rtl/instr_buffer_if.sv
// instr_buffer_if: fetch push, dispatch pop and squash signals of the instruction buffer.
interface instr_buffer_if #(parameter int IB_DEPTH = instr_buffer_pkg::IB_DEPTH_DEFAULT);
    import instr_buffer_pkg::*;
    IF_IB_PACKET                   if_ib_packet;
    IF_IB_PACKET                   ib_dp_packet;
    logic                          squash;
    logic                          dp_ready;
    logic                          ib_full;
    logic                          ib_empty;
    logic [$clog2(IB_DEPTH+1)-1:0] ib_count;
    modport master (output if_ib_packet, squash, dp_ready, input ib_dp_packet, ib_full, ib_empty, ib_count);
    modport slave (input if_ib_packet, squash, dp_ready, output ib_dp_packet, ib_full, ib_empty, ib_count);
endinterface

// File: rtl/instr_buffer.sv
// instr_buffer: circular FIFO of fetched packets between fetch and dispatch.
// Optional IB_BYPASS_EN forwards a packet pushed into an empty buffer to dispatch in the same cycle.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int IB_DEPTH = IB_DEPTH_DEFAULT
) (
    input logic            clock,
    input logic            reset,
    instr_buffer_if.slave  ib
);
    localparam int PW = $clog2(IB_DEPTH);
    localparam int CW = $clog2(IB_DEPTH+1);
    IF_IB_PACKET   entries_q [IB_DEPTH];
    IF_IB_PACKET   entries_d [IB_DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, wr, bypass;
    // Status flags come from registered count only, so fetch's PC_valid sees no loop.
    assign ib.ib_full  = count_q == CW'(IB_DEPTH);
    assign ib.ib_empty = count_q == '0;
    assign ib.ib_count = count_q;
    always_comb begin
        push = ib.if_ib_packet.valid && !ib.ib_full;
`ifdef IB_BYPASS_EN
        bypass = push && count_q == '0;
`else
        bypass = 1'b0;
`endif
        ib.ib_dp_packet = bypass ? ib.if_ib_packet : (count_q != '0 ? entries_q[head_q] : IF_IB_PACKET'(0));
        pop = count_q != '0 && ib.dp_ready;
        wr = push && !(bypass && ib.dp_ready);
        entries_d = entries_q;
        if (wr) entries_d[tail_q] = ib.if_ib_packet;
        head_d = ib.squash ? '0 : head_q + PW'(pop);
        tail_d = ib.squash ? '0 : tail_q + PW'(wr);
        count_d = ib.squash ? '0 : count_q + CW'(wr) - CW'(pop);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < IB_DEPTH; i++) entries_q[i] <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end
    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset) !(ib.if_ib_packet.valid && ib.ib_full))
        else $warning("instr_buffer: valid packet offered while ib_full, dropped");
endmodule
